// File: rtl/beta_pkg.sv
// Shared definitions for the Beta program-counter slice: pcsel codes,
// default vectors and the interrupt FSM state type.
package beta_pkg;

    localparam logic [2:0] PCSEL_NORMAL = 3'b000;
    localparam logic [2:0] PCSEL_BEQ    = 3'b001;
    localparam logic [2:0] PCSEL_BNE    = 3'b010;
    localparam logic [2:0] PCSEL_JMP    = 3'b011;
    localparam logic [2:0] PCSEL_TRAP   = 3'b100;

    localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] DEF_XADR_VEC  = 32'h8000_0008;

    typedef enum logic {
        IRQ_IDLE,
        IRQ_PENDING
    } irq_state_e;

endpackage

// File: rtl/beta_pc_target.sv
// Combinational branch and jump target calculator; bit W-1 of each target
// is the supervisor bit and is never produced by an address carry.
module beta_pc_target #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] pc_next_i,
    input  logic [15:0]  offset_i,
    input  logic [W-1:0] jmp_addr_i,
    input  logic         supervisor_i,
    output logic [W-1:0] br_target_o,
    output logic [W-1:0] jmp_target_o
);

    logic [W+17:0] off_wide;
    logic [W-2:0]  br_sum;
    logic          unused_bits;

    // Sign-extended word offset scaled to bytes, wide enough for any W >= 8.
    assign off_wide = {{W{offset_i[15]}}, offset_i, 2'b00};
    assign br_sum   = pc_next_i[W-2:0] + off_wide[W-2:0];

    assign br_target_o  = {supervisor_i, br_sum};
    assign jmp_target_o = {supervisor_i & jmp_addr_i[W-1], jmp_addr_i[W-2:2], 2'b00};

    assign unused_bits = ^{pc_next_i[W-1], jmp_addr_i[1:0], off_wide[W+17:W-1]};

endmodule

// File: rtl/beta_pc_unit.sv
// Beta program counter: PC/supervisor state, next-PC selection, exception
// pointer and a two-state interrupt latch.
module beta_pc_unit
    import beta_pkg::*;
#(
    parameter int unsigned   W         = 32,
    parameter logic [W-1:0]  RESET_VEC = W'(DEF_RESET_VEC),
    parameter logic [W-1:0]  ILLOP_VEC = W'(DEF_ILLOP_VEC),
    parameter logic [W-1:0]  XADR_VEC  = W'(DEF_XADR_VEC)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         stall,
    input  logic [2:0]   pcsel,
    input  logic [W-1:0] ra_val,
    input  logic [15:0]  offset,
    input  logic [W-1:0] jmp_addr,
    input  logic         irq,
    output logic [W-1:0] pc_out,
    output logic [W-1:0] pc_next,
    output logic [W-1:0] xp_out,
    output logic         supervisor,
    output logic         branch_taken,
    output logic         irq_taken
);

    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] pcn_q, pcn_d;
    logic [W-1:0] xp_q, xp_d;
    logic         bt_q, bt_d;
    logic         it_q, it_d;
    irq_state_e   state_q, state_d;

    logic [W-1:0] br_target;
    logic [W-1:0] jmp_target;
    logic [W-1:0] reset_next;
    logic         adv;
    logic         is_trap;
    logic         irq_take;

    beta_pc_target #(.W(W)) u_target (
        .pc_next_i    (pcn_q),
        .offset_i     (offset),
        .jmp_addr_i   (jmp_addr),
        .supervisor_i (pc_q[W-1]),
        .br_target_o  (br_target),
        .jmp_target_o (jmp_target)
    );

    assign adv        = clk_en & ~stall;
    assign is_trap    = pcsel[2];
    assign irq_take   = (state_q == IRQ_PENDING) & adv & ~pc_q[W-1] & ~is_trap;
    assign reset_next = {RESET_VEC[W-1], RESET_VEC[W-2:0] + (W-1)'(4)};

    always_comb begin
        pc_d    = pc_q;
        xp_d    = xp_q;
        bt_d    = 1'b0;
        it_d    = 1'b0;
        state_d = state_q;
        // The latch captures irq on every edge, even while the PC is held.
        if (irq) begin
            state_d = IRQ_PENDING;
        end
        if (adv) begin
            if (is_trap) begin
                xp_d = pcn_q;
                pc_d = ILLOP_VEC;
            end else if (irq_take) begin
                xp_d    = pcn_q;
                pc_d    = XADR_VEC;
                it_d    = 1'b1;
                state_d = IRQ_IDLE;
            end else begin
                case (pcsel)
                    PCSEL_BEQ: begin
                        bt_d = (ra_val == '0);
                        pc_d = bt_d ? br_target : pcn_q;
                    end
                    PCSEL_BNE: begin
                        bt_d = (ra_val != '0);
                        pc_d = bt_d ? br_target : pcn_q;
                    end
                    PCSEL_JMP: pc_d = jmp_target;
                    default:   pc_d = pcn_q;
                endcase
            end
        end
        pcn_d = {pc_d[W-1], pc_d[W-2:0] + (W-1)'(4)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VEC;
            pcn_q   <= reset_next;
            xp_q    <= '0;
            bt_q    <= 1'b0;
            it_q    <= 1'b0;
            state_q <= IRQ_IDLE;
        end else begin
            pc_q    <= pc_d;
            pcn_q   <= pcn_d;
            xp_q    <= xp_d;
            bt_q    <= bt_d;
            it_q    <= it_d;
            state_q <= state_d;
        end
    end

    assign pc_out       = pc_q;
    assign pc_next      = pcn_q;
    assign xp_out       = xp_q;
    assign supervisor   = pc_q[W-1];
    assign branch_taken = bt_q;
    assign irq_taken    = it_q;

endmodule

// File: tb/tb_beta_pc_unit.sv
// Directed bench for beta_pc_unit: each step queues its expected outputs,
// which are popped and compared one cycle later.
module tb_beta_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_en = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  pcsel = 3'b000;
    logic [31:0] ra_val = '0;
    logic [15:0] offset = '0;
    logic [31:0] jmp_addr = '0;
    logic        irq = 1'b0;
    logic [31:0] pc_out, pc_next, xp_out;
    logic        supervisor, branch_taken, irq_taken;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] xp;
        logic        bt;
        logic        it;
    } exp_t;

    exp_t sb[$];

    beta_pc_unit #(.W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .stall        (stall),
        .pcsel        (pcsel),
        .ra_val       (ra_val),
        .offset       (offset),
        .jmp_addr     (jmp_addr),
        .irq          (irq),
        .pc_out       (pc_out),
        .pc_next      (pc_next),
        .xp_out       (xp_out),
        .supervisor   (supervisor),
        .branch_taken (branch_taken),
        .irq_taken    (irq_taken)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic ce, input logic st,
                        input logic [2:0] sel, input logic [31:0] ra, input logic [15:0] off,
                        input logic [31:0] ja, input logic iq,
                        input logic [31:0] epc, input logic [31:0] exp_xp,
                        input logic ebt, input logic eit);
        exp_t e;
        logic [31:0] epcn;
        @(negedge clk);
        rst = r; clk_en = ce; stall = st; pcsel = sel;
        ra_val = ra; offset = off; jmp_addr = ja; irq = iq;
        sb.push_back('{tag: tag, pc: epc, xp: exp_xp, bt: ebt, it: eit});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        epcn = {e.pc[31], e.pc[30:0] + 31'd4};
        cmp({e.tag, ".pc"},  pc_out, e.pc);
        cmp({e.tag, ".pcn"}, pc_next, epcn);
        cmp({e.tag, ".xp"},  xp_out, e.xp);
        cmp({e.tag, ".sup"}, {31'd0, supervisor}, {31'd0, e.pc[31]});
        cmp({e.tag, ".bt"},  {31'd0, branch_taken}, {31'd0, e.bt});
        cmp({e.tag, ".it"},  {31'd0, irq_taken}, {31'd0, e.it});
    endtask

    initial begin
        //   tag          rst ce st sel     ra  off       jmp          irq  pc            xp            bt  it
        step("reset",     1, 0, 0, 3'd0, 0, 16'h0000, 32'h0,        0, 32'h8000_0000, 32'h0,   0, 0);
        step("norm1",     0, 1, 0, 3'd0, 0, 16'h0000, 32'h0,        0, 32'h8000_0004, 32'h0,   0, 0);
        step("norm2",     0, 1, 0, 3'd0, 0, 16'h0000, 32'h0,        0, 32'h8000_0008, 32'h0,   0, 0);
        step("norm3",     0, 1, 0, 3'd0, 0, 16'h0000, 32'h0,        0, 32'h8000_000C, 32'h0,   0, 0);
        step("norm4",     0, 1, 0, 3'd0, 0, 16'h0000, 32'h0,        0, 32'h8000_0010, 32'h0,   0, 0);
        // JMP leaves supervisor mode and aligns; from user it cannot re-enter.
        step("jmp_s2u",   0, 1, 0, 3'd3, 0, 16'h0000, 32'h0000_0203, 0, 32'h0000_0200, 32'h0,  0, 0);
        step("jmp_u2s",   0, 1, 0, 3'd3, 0, 16'h0000, 32'h8000_0040, 0, 32'h0000_0040, 32'h0,  0, 0);
        step("jmp100",    0, 1, 0, 3'd3, 0, 16'h0000, 32'h0000_0100, 0, 32'h0000_0100, 32'h0,  0, 0);
        step("beq_tk",    0, 1, 0, 3'd1, 0, 16'hFFFE, 32'h0,        0, 32'h0000_00FC, 32'h0,   1, 0);
        step("after_beq", 0, 1, 0, 3'd0, 0, 16'h0000, 32'h0,        0, 32'h0000_0100, 32'h0,   0, 0);
        step("jmp100b",   0, 1, 0, 3'd3, 0, 16'h0000, 32'h0000_0100, 0, 32'h0000_0100, 32'h0,  0, 0);
        step("beq_nt",    0, 1, 0, 3'd1, 5, 16'hFFFE, 32'h0,        0, 32'h0000_0104, 32'h0,   0, 0);
        step("bne_tk",    0, 1, 0, 3'd2, 5, 16'h0001, 32'h0,        0, 32'h0000_010C, 32'h0,   1, 0);
        step("bne_nt",    0, 1, 0, 3'd2, 0, 16'h0001, 32'h0,        0, 32'h0000_0110, 32'h0,   0, 0);
        step("stall",     0, 1, 1, 3'd3, 0, 16'h0000, 32'h0000_0500, 0, 32'h0000_0110, 32'h0,  0, 0);
        step("clken0",    0, 0, 0, 3'd1, 0, 16'h0010, 32'h0,        0, 32'h0000_0110, 32'h0,   0, 0);
        // Interrupt raised during a stall is held pending, then taken.
        step("jmp20",     0, 1, 0, 3'd3, 0, 16'h0000, 32'h0000_0020, 0, 32'h0000_0020, 32'h0,  0, 0);
        step("irq_st1",   0, 1, 1, 3'd0, 0, 16'h0000, 32'h0,        1, 32'h0000_0020, 32'h0,   0, 0);
        step("irq_st2",   0, 1, 1, 3'd0, 0, 16'h0000, 32'h0,        0, 32'h0000_0020, 32'h0,   0, 0);
        step("irq_take",  0, 1, 0, 3'd3, 0, 16'h0000, 32'h0000_0400, 0, 32'h8000_0008, 32'h24, 0, 1);
        step("irq_after", 0, 1, 0, 3'd0, 0, 16'h0000, 32'h0,        0, 32'h8000_000C, 32'h24,  0, 0);
        step("irq_sup1",  0, 1, 0, 3'd0, 0, 16'h0000, 32'h0,        1, 32'h8000_0010, 32'h24,  0, 0);
        step("irq_sup2",  0, 1, 0, 3'd0, 0, 16'h0000, 32'h0,        0, 32'h8000_0014, 32'h24,  0, 0);
        step("irq_jmpu",  0, 1, 0, 3'd3, 0, 16'h0000, 32'h0000_0300, 0, 32'h0000_0300, 32'h24, 0, 0);
        step("irq_take2", 0, 1, 0, 3'd0, 0, 16'h0000, 32'h0,        0, 32'h8000_0008, 32'h304, 0, 1);
        step("after2",    0, 1, 0, 3'd0, 0, 16'h0000, 32'h0,        0, 32'h8000_000C, 32'h304, 0, 0);
        // TRAP wins over a simultaneous irq, which is taken later.
        step("jmp40",     0, 1, 0, 3'd3, 0, 16'h0000, 32'h0000_0040, 0, 32'h0000_0040, 32'h304, 0, 0);
        step("trap_irq",  0, 1, 0, 3'd4, 0, 16'h0000, 32'h0,        1, 32'h8000_0004, 32'h44,  0, 0);
        step("jmp80",     0, 1, 0, 3'd3, 0, 16'h0000, 32'h0000_0080, 0, 32'h0000_0080, 32'h44, 0, 0);
        step("irq_take3", 0, 1, 0, 3'd0, 0, 16'h0000, 32'h0,        0, 32'h8000_0008, 32'h84,  0, 1);
        step("jmp_wrap",  0, 1, 0, 3'd3, 0, 16'h0000, 32'h7FFF_FFFC, 0, 32'h7FFF_FFFC, 32'h84, 0, 0);
        step("wrap",      0, 1, 0, 3'd0, 0, 16'h0000, 32'h0,        0, 32'h0000_0000, 32'h84,  0, 0);
        step("trap110",   0, 1, 0, 3'd6, 0, 16'h0000, 32'h0,        0, 32'h8000_0004, 32'h4,   0, 0);
        // Reset during a stall with an interrupt pending clears everything.
        step("pend_st",   0, 1, 1, 3'd0, 0, 16'h0000, 32'h0,        1, 32'h8000_0004, 32'h4,   0, 0);
        step("rst_st",    1, 1, 1, 3'd0, 0, 16'h0000, 32'h0,        0, 32'h8000_0000, 32'h0,   0, 0);
        step("jmp50",     0, 1, 0, 3'd3, 0, 16'h0000, 32'h0000_0050, 0, 32'h0000_0050, 32'h0,  0, 0);
        step("no_pend",   0, 1, 0, 3'd0, 0, 16'h0000, 32'h0,        0, 32'h0000_0054, 32'h0,   0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
